inst_decode_stage: RTL and testbench
====================================

// Module: inst_decode_stage
// PURPOSE
//  Registered, back-pressurable RV32I decode pipeline stage sitting between fetch and execute.
//  Splits each 32-bit instruction into fields, builds the sign-extended immediate,
//  classifies the format, flags illegal encodings and computes the rd write-enable.
//  Valid/ready on both sides; a skid register keeps full throughput under stalls.
// PARAMETERS
//  XLEN     32  datapath width for pc/imm; 32 or 64; imm sign-extended to XLEN
//  SKID_EN  1   1: 2-entry skid (in_ready registered); 0: in_ready = !out_valid | out_ready
//  SYS_EN   1   1: ECALL/EBREAK legal; 0: whole SYSTEM opcode flagged illegal
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  flush        in   1     sync kill of all held instructions (branch mispredict/trap)
//  in_valid     in   1     fetch presents in_inst/in_pc
//  in_ready     out  1     stage accepts this cycle
//  in_inst      in   32    raw instruction
//  in_pc        in   XLEN  instruction address
//  out_valid    out  1     decoded bundle valid
//  out_ready    in   1     execute accepts bundle
//  out_pc       out  XLEN  pc of bundle
//  out_opcode   out  7     inst[6:0]
//  out_funct3   out  3     inst[14:12]
//  out_funct7   out  7     inst[31:25]
//  out_rd/rs1/rs2 out 5 each  inst[11:7] / [19:15] / [24:20]
//  out_imm      out  XLEN  sign-extended immediate; 0 for R-type and illegal
//  out_itype    out  3     R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//  out_illegal  out  1     encoding not legal RV32I
//  out_rd_we    out  1     instruction writes rd
// BEHAVIOUR
//  - Reset: out_valid=0, skid empty, in_ready=1, every data output 0.
//  - Latency 1: bundle accepted on cycle N (in_valid&in_ready) appears with out_valid on N+1.
//  - Bundle held stable while out_valid & !out_ready; never dropped, reordered or duplicated.
//  - SKID_EN=1: accept with out stage full and !out_ready -> store in skid; in_ready=0 next cycle.
//    On out_ready, skid moves to out stage; in_ready returns to 1 the following cycle.
//    Accept and drain in the same cycle: out stage takes skid (if full) else the new input.
//  - SKID_EN=0: combinational in_ready; no skid storage.
//  - flush: next cycle out_valid=0, skid empty, in_ready=1. Input offered during flush is dropped.
//    Flush takes priority over any simultaneous accept or drain.
//  - Decode keys on inst[6:2]: LOAD,OP_IMM,JALR,MISC_MEM,SYSTEM -> I; STORE -> S; BRANCH -> B;
//    OP -> R; LUI,AUIPC -> U; JAL -> J. Any other opcode -> ILL.
//  - Immediates (sign bit inst[31] replicated to XLEN): I {31:20}; S {31:25,11:7};
//    B {31,7,30:25,11:8,0}; U {31:12,12'b0}; J {31,19:12,20,30:21,0}.
//  - Illegal if any of: inst[1:0]!=2'b11; unknown opcode; LOAD f3 in {011,110,111};
//    STORE f3>010; BRANCH f3 in {010,011}; JALR f3!=0; OP f7 not 0x00/0x20, or f7=0x20 with
//    f3 not 000/101; OP_IMM f3=001 with f7!=0, f3=101 with f7 not 0x00/0x20;
//    SYSTEM when SYS_EN=0, or not exactly 0x00000073/0x00100073.
//  - Illegal bundle: itype=7, imm=0, rd_we=0; still passes through with out_valid (trap downstream).
//  - rd_we=1 only for legal LOAD,OP_IMM,OP,LUI,AUIPC,JAL,JALR with rd!=0; MISC_MEM treated as NOP, rd_we=0.
//  - Reset asserted mid-stream: all held bundles discarded immediately (async), no partial output.
// TESTING
//  - addi x1,x0,-1 (0xFFF00093) -> itype=1, imm=0xFFFFFFFF (XLEN=64: all ones), rd_we=1, 1-cycle latency.
//  - beq 0xFE000EE3 -> itype=3, imm=-4, rd_we=0; jal x0 0x0000006F -> itype=5, imm=0, rd_we=0.
//  - 0xFFFFFFFF and OP f7=0x01 (0x02208033) -> out_illegal=1, itype=7, imm=0, rd_we=0.
//  - Stream 4 insts, out_ready low 3 cycles after the first: skid fills, in_ready=0,
//    outputs in order, no loss; back-to-back rate restored with out_ready high.
//  - flush with out stage and skid full plus in_valid high -> next cycle out_valid=0, in_ready=1.
//  - SYS_EN=0: ecall 0x00000073 -> illegal; SYS_EN=1: ecall legal, 0x10200073 illegal.

Source files
------------

// File: rtl/inst_decode_stage_if.sv
// Handshake and bundle signals between fetch, decode and execute.
// master drives instructions in and accepts bundles; slave is the stage.
interface inst_decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_itype;
   logic            out_illegal;
   logic            out_rd_we;

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode,
      input  out_funct3, out_funct7, out_rd, out_rs1,
      input  out_rs2, out_imm, out_itype, out_illegal,
      input  out_rd_we
   );

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_opcode,
      output out_funct3, out_funct7, out_rd, out_rs1,
      output out_rs2, out_imm, out_itype, out_illegal,
      output out_rd_we
   );
endinterface

// File: rtl/inst_decode_stage.sv
// RV32I decode pipeline stage: field split, immediate build, legality check.
// Registered output with an optional skid entry so in_ready stays registered.
module inst_decode_stage #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1,
   parameter bit SYS_EN  = 1'b1
) (
   input logic clk,
   input logic rst_n,
   input logic flush,
   inst_decode_stage_if.slave bus
);

   localparam logic [2:0] T_R   = 3'd0;
   localparam logic [2:0] T_I   = 3'd1;
   localparam logic [2:0] T_S   = 3'd2;
   localparam logic [2:0] T_B   = 3'd3;
   localparam logic [2:0] T_U   = 3'd4;
   localparam logic [2:0] T_J   = 3'd5;
   localparam logic [2:0] T_ILL = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [2:0]      itype;
      logic            illegal;
      logic            rd_we;
   } bundle_t;

   logic [31:0] inst;
   logic [4:0]  op;
   logic [2:0]  f3;
   logic [6:0]  f7;

   assign inst = bus.in_inst;
   assign op   = inst[6:2];
   assign f3   = inst[14:12];
   assign f7   = inst[31:25];

   logic is_load, is_misc, is_opimm, is_auipc;
   logic is_store, is_op, is_lui, is_branch;
   logic is_jalr, is_jal, is_sys;

   assign is_load   = op == 5'b00000;
   assign is_misc   = op == 5'b00011;
   assign is_opimm  = op == 5'b00100;
   assign is_auipc  = op == 5'b00101;
   assign is_store  = op == 5'b01000;
   assign is_op     = op == 5'b01100;
   assign is_lui    = op == 5'b01101;
   assign is_branch = op == 5'b11000;
   assign is_jalr   = op == 5'b11001;
   assign is_jal    = op == 5'b11011;
   assign is_sys    = op == 5'b11100;

   logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};

   logic [2:0]         ty;
   logic signed [31:0] imm32;
   logic               bad;
   logic               wr;

   // Classify format, pick immediate and flag illegal encodings.
   always_comb begin
      ty    = T_ILL;
      imm32 = '0;
      bad   = 1'b0;
      wr    = 1'b0;
      unique case (1'b1)
         is_load: begin
            ty    = T_I;
            imm32 = imm_i;
            bad   = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            wr    = 1'b1;
         end
         is_misc: begin
            ty    = T_I;
            imm32 = imm_i;
         end
         is_opimm: begin
            ty    = T_I;
            imm32 = imm_i;
            bad   = ((f3 == 3'b001) && (f7 != 7'h00))
                 || ((f3 == 3'b101) && (f7 != 7'h00)
                     && (f7 != 7'h20));
            wr    = 1'b1;
         end
         is_jalr: begin
            ty    = T_I;
            imm32 = imm_i;
            bad   = f3 != 3'b000;
            wr    = 1'b1;
         end
         is_sys: begin
            ty    = T_I;
            imm32 = imm_i;
            bad   = !SYS_EN
                 || !((inst == 32'h0000_0073)
                      || (inst == 32'h0010_0073));
         end
         is_store: begin
            ty    = T_S;
            imm32 = imm_s;
            bad   = f3 > 3'b010;
         end
         is_branch: begin
            ty    = T_B;
            imm32 = imm_b;
            bad   = f3[2:1] == 2'b01;
         end
         is_op: begin
            ty    = T_R;
            bad   = ((f7 != 7'h00) && (f7 != 7'h20))
                 || ((f7 == 7'h20) && (f3 != 3'b000)
                     && (f3 != 3'b101));
            wr    = 1'b1;
         end
         is_lui, is_auipc: begin
            ty    = T_U;
            imm32 = imm_u;
            wr    = 1'b1;
         end
         is_jal: begin
            ty    = T_J;
            imm32 = imm_j;
            wr    = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      if (inst[1:0] != 2'b11) bad = 1'b1;
      if (bad) begin
         ty    = T_ILL;
         imm32 = '0;
         wr    = 1'b0;
      end
      if (inst[11:7] == 5'd0) wr = 1'b0;
   end

   bundle_t dec;

   // Assemble the decoded bundle for the instruction on the input.
   always_comb begin
      dec         = '0;
      dec.pc      = bus.in_pc;
      dec.opcode  = inst[6:0];
      dec.funct3  = f3;
      dec.funct7  = f7;
      dec.rd      = inst[11:7];
      dec.rs1     = inst[19:15];
      dec.rs2     = inst[24:20];
      dec.imm     = XLEN'(imm32);
      dec.itype   = ty;
      dec.illegal = bad;
      dec.rd_we   = wr;
   end

   bundle_t out_q;
   bundle_t skid_q;
   logic    out_valid;
   logic    skid_valid;
   logic    acc;
   logic    load_out;

   // Without a skid entry the stage only accepts when the output frees.
   assign bus.in_ready = SKID_EN ? !skid_valid
                                 : (!out_valid || bus.out_ready);
   assign acc      = bus.in_valid && bus.in_ready;
   assign load_out = !out_valid || bus.out_ready;

   // Output register refills from skid first to keep program order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (load_out) begin
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (acc) begin
            out_q     <= dec;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (acc) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign bus.out_valid   = out_valid;
   assign bus.out_pc      = out_q.pc;
   assign bus.out_opcode  = out_q.opcode;
   assign bus.out_funct3  = out_q.funct3;
   assign bus.out_funct7  = out_q.funct7;
   assign bus.out_rd      = out_q.rd;
   assign bus.out_rs1     = out_q.rs1;
   assign bus.out_rs2     = out_q.rs2;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_itype   = out_q.itype;
   assign bus.out_illegal = out_q.illegal;
   assign bus.out_rd_we   = out_q.rd_we;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Randomized scoreboard bench for the decode stage.
// A spec-level reference decoder predicts each bundle at acceptance.
module tb_inst_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [2:0]  itype;
      logic        ill;
      logic        we;
   } exp_t;

   localparam logic [6:0] OPS [11] = '{
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73
   };

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   exp_t q[$];
   exp_t held;
   bit   stall_hold = 0;

   inst_decode_stage_if #(.XLEN(32)) ifc ();
   inst_decode_stage_if #(.XLEN(32)) ifs ();

   inst_decode_stage #(
      .XLEN(32), .SKID_EN(1'b1), .SYS_EN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifc)
   );

   inst_decode_stage #(
      .XLEN(32), .SKID_EN(1'b1), .SYS_EN(1'b0)
   ) dut_nosys (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(ifs)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference decoder built from the ISA rules with integer arithmetic.
   function automatic exp_t model(input logic [31:0] w,
                                  input logic [31:0] pc,
                                  input bit sys_en);
      exp_t e;
      int   s, f3, f7, sg;
      bit   ill, wr;
      int   ty;
      int   imm;
      s  = w;
      sg = s >>> 31;
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      ill = 0; wr = 0; ty = 7; imm = 0;
      case (w[6:0])
         7'h03: begin
            ty = 1; imm = s >>> 20; wr = 1;
            ill = f3 inside {3, 6, 7};
         end
         7'h0F: begin ty = 1; imm = s >>> 20; end
         7'h13: begin
            ty = 1; imm = s >>> 20; wr = 1;
            ill = (f3 == 1 && f7 != 0)
               || (f3 == 5 && !(f7 inside {0, 32}));
         end
         7'h17, 7'h37: begin
            ty = 4; imm = s & 32'hFFFF_F000; wr = 1;
         end
         7'h23: begin
            ty = 2; ill = f3 > 2;
            imm = (s >>> 25) * 32 + int'(w[11:7]);
         end
         7'h33: begin
            ty = 0; wr = 1;
            ill = !(f7 inside {0, 32})
               || (f7 == 32 && !(f3 inside {0, 5}));
         end
         7'h63: begin
            ty = 3; ill = f3 inside {2, 3};
            imm = sg * 4096 + int'(w[7]) * 2048
                + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
         end
         7'h67: begin
            ty = 1; imm = s >>> 20; wr = 1; ill = f3 != 0;
         end
         7'h6F: begin
            ty = 5; wr = 1;
            imm = sg * (1 << 20) + int'(w[19:12]) * 4096
                + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
         end
         7'h73: begin
            ty = 1; imm = s >>> 20;
            ill = !sys_en
               || !(w == 32'h73 || w == 32'h0010_0073);
         end
         default: ill = 1;
      endcase
      if (ill) begin ty = 7; imm = 0; wr = 0; end
      if (w[11:7] == 0) wr = 0;
      e.pc = pc;         e.opcode = w[6:0];
      e.f3 = w[14:12];   e.f7 = w[31:25];
      e.rd = w[11:7];    e.rs1 = w[19:15];
      e.rs2 = w[24:20];  e.imm = imm;
      e.itype = 3'(ty);  e.ill = ill;
      e.we = wr;
      return e;
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.pc = ifc.out_pc;         a.opcode = ifc.out_opcode;
      a.f3 = ifc.out_funct3;     a.f7 = ifc.out_funct7;
      a.rd = ifc.out_rd;         a.rs1 = ifc.out_rs1;
      a.rs2 = ifc.out_rs2;       a.imm = ifc.out_imm;
      a.itype = ifc.out_itype;   a.ill = ifc.out_illegal;
      a.we = ifc.out_rd_we;
      return a;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) == 0) return w;
      w[6:0] = OPS[$urandom_range(0, 10)];
      if ($urandom_range(0, 2) == 0)
         w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1)
         w = $urandom_range(0, 1) ? 32'h73 : 32'h0010_0073;
      return w;
   endfunction

   // Monitor: push predictions on accept, pop and compare on drain.
   always @(negedge clk) begin
      exp_t a, e;
      if (!rst_n || flush) begin
         q.delete();
         stall_hold = 0;
      end else begin
         a = actual();
         if (stall_hold) begin
            vectors++;
            if (!ifc.out_valid || a !== held) begin
               miscompares++;
               $display("FAIL hold: got v=%b %h required %h",
                        ifc.out_valid, a, held);
            end
         end
         if (ifc.out_valid && ifc.out_ready) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL extra: got bundle %h required none", a);
            end else begin
               e = q.pop_front();
               if (a !== e) begin
                  miscompares++;
                  $display("FAIL bundle: got %h required %h", a, e);
               end
            end
         end
         stall_hold = ifc.out_valid && !ifc.out_ready;
         held = a;
         if (ifc.in_valid && ifc.in_ready)
            q.push_back(model(ifc.in_inst, ifc.in_pc, 1'b1));
      end
   end

   task automatic send(input logic [31:0] w, input logic [31:0] pc);
      bit acc = 0;
      ifc.in_valid = 1'b1;
      ifc.in_inst  = w;
      ifc.in_pc    = pc;
      for (int n = 0; n < 64 && !acc; n++) begin
         @(negedge clk);
         acc = ifc.in_ready;
         @(posedge clk); #1;
      end
      chk("send_accept", 64'(acc), 64'd1);
   endtask

   task automatic dir(input string name, input logic [31:0] w,
                      input logic [2:0] ty, input logic [31:0] imm,
                      input bit ill, input bit we);
      ifc.out_ready = 1'b1;
      send(w, 32'h0000_1000);
      ifc.in_valid = 1'b0;
      chk({name, "_valid"}, 64'(ifc.out_valid), 64'd1);
      chk({name, "_dec"},
          {ifc.out_itype, ifc.out_imm, ifc.out_illegal, ifc.out_rd_we},
          {ty, imm, ill, we});
   endtask

   initial begin
      int t0;
      rst_n = 1'b0;
      flush = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_inst = '0;
      ifc.in_pc = '0;      ifc.out_ready = 1'b0;
      ifs.in_valid = 1'b0; ifs.in_inst = '0;
      ifs.in_pc = '0;      ifs.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
      chk("rst_pc_imm", {ifc.out_pc, ifc.out_imm}, 64'd0);
      chk("rst_fields",
          {ifc.out_opcode, ifc.out_funct3, ifc.out_funct7,
           ifc.out_rd, ifc.out_rs1, ifc.out_rs2, ifc.out_itype,
           ifc.out_illegal, ifc.out_rd_we}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      dir("addi", 32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF, 0, 1);
      dir("beq", 32'hFE00_0EE3, 3'd3, 32'hFFFF_FFFC, 0, 0);
      dir("jal0", 32'h0000_006F, 3'd5, 32'h0, 0, 0);
      dir("ones", 32'hFFFF_FFFF, 3'd7, 32'h0, 1, 0);
      dir("opf7", 32'h0220_8033, 3'd7, 32'h0, 1, 0);
      dir("ecall", 32'h0000_0073, 3'd1, 32'h0, 0, 0);
      dir("sysbad", 32'h1020_0073, 3'd7, 32'h0, 1, 0);
      dir("lui", 32'h8000_0537, 3'd4, 32'h8000_0000, 0, 1);

      // Skid fill: out_ready low for three cycles after the first.
      @(posedge clk); #1;
      ifc.out_ready = 1'b1;
      send(32'h0010_0113, 32'h200);
      ifc.out_ready = 1'b0;
      send(32'h0020_0193, 32'h204);
      chk("skid_in_ready", 64'(ifc.in_ready), 64'd0);
      chk("skid_out_valid", 64'(ifc.out_valid), 64'd1);
      ifc.in_inst = 32'h0030_0213;
      ifc.in_pc   = 32'h208;
      repeat (2) begin
         @(posedge clk); #1;
         chk("skid_hold_ready", 64'(ifc.in_ready), 64'd0);
      end
      ifc.out_ready = 1'b1;
      send(32'h0030_0213, 32'h208);
      send(32'h0040_0293, 32'h20C);
      t0 = cyc;
      for (int i = 0; i < 8; i++)
         send(rand_inst(), 32'h300 + 32'(i * 4));
      chk("throughput", 64'(cyc - t0), 64'd8);
      ifc.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Flush with output and skid both full and input offered.
      ifc.out_ready = 1'b0;
      send(32'h0050_0313, 32'h400);
      send(32'h0060_0393, 32'h404);
      ifc.in_valid = 1'b1;
      ifc.in_inst  = 32'h0070_0413;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      ifc.in_valid = 1'b0;
      chk("flush_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("flush_in_ready", 64'(ifc.in_ready), 64'd1);
      ifc.out_ready = 1'b1;
      send(32'h0080_0493, 32'h500);
      ifc.in_valid = 1'b0;

      // Asynchronous reset while a bundle is held.
      ifc.out_ready = 1'b0;
      send(32'h0090_0513, 32'h600);
      ifc.in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(ifc.out_valid), 64'd0);
      chk("arst_in_ready", 64'(ifc.in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Random traffic with back-pressure and occasional flush.
      for (int c = 0; c < 2500; c++) begin
         ifc.in_valid  = $urandom_range(0, 9) < 7;
         ifc.in_inst   = rand_inst();
         ifc.in_pc     = $urandom & 32'hFFFF_FFFC;
         ifc.out_ready = $urandom_range(0, 9) < 7;
         flush         = $urandom_range(0, 49) == 0;
         @(posedge clk); #1;
      end
      flush = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      for (int n = 0; n < 20 && q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);

      // SYSTEM opcode disabled: ecall and ebreak both illegal.
      ifs.in_valid = 1'b1;
      ifs.in_inst  = 32'h0000_0073;
      @(posedge clk); #1;
      ifs.in_inst  = 32'h0010_0073;
      chk("nosys_ecall",
          {ifs.out_valid, ifs.out_illegal, ifs.out_itype},
          {1'b1, 1'b1, 3'd7});
      @(posedge clk); #1;
      ifs.in_valid = 1'b0;
      chk("nosys_ebreak",
          {ifs.out_valid, ifs.out_illegal, ifs.out_itype},
          {1'b1, 1'b1, 3'd7});

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
